// File: rtl/chiplet_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chiplet_types_pkg
// Description : Shared types for the chiplet router switch allocator.
// Revision    : 1.0 - initial release
// ============================================================================
package chiplet_types_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_t;

  localparam int unsigned c_default_buffer_depth = 8;
  localparam int unsigned c_credit_cnt_w         = $clog2(c_default_buffer_depth + 1);

  // Credit counter for the default downstream depth; other depths size their own.
  typedef logic [c_credit_cnt_w-1:0] credit_cnt_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_allocator_if.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator_if
// Description : Request/grant/credit bundle between input buffers, links and
//               the switch allocator. credit_err exists with
//               SWITCH_ALLOC_CREDIT_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface switch_allocator_if #(
  parameter int NUM_INPORTS  = 4,
  parameter int NUM_OUTPORTS = 4,
  parameter int NUM_VCS      = 2
);
  localparam int c_vc_w = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

  logic [NUM_INPORTS-1:0][NUM_OUTPORTS-1:0] req;
  logic [NUM_INPORTS-1:0][c_vc_w-1:0]       req_vc;
  logic [NUM_INPORTS-1:0]                   req_tail;
  logic [NUM_OUTPORTS-1:0]                  flit_sent;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]     credit_granted;
  logic [NUM_OUTPORTS-1:0][NUM_INPORTS-1:0] grant;
  logic [NUM_OUTPORTS-1:0]                  vc_ready;
  logic [NUM_OUTPORTS-1:0]                  busy;
`ifdef SWITCH_ALLOC_CREDIT_ERR_EN
  logic [NUM_OUTPORTS-1:0]                  credit_err;

  modport master (
    output req, req_vc, req_tail, flit_sent, credit_granted,
    input  grant, vc_ready, busy, credit_err
  );
  modport slave (
    input  req, req_vc, req_tail, flit_sent, credit_granted,
    output grant, vc_ready, busy, credit_err
  );
`else
  modport master (
    output req, req_vc, req_tail, flit_sent, credit_granted,
    input  grant, vc_ready, busy
  );
  modport slave (
    input  req, req_vc, req_tail, flit_sent, credit_granted,
    output grant, vc_ready, busy
  );
`endif

endinterface
`default_nettype wire

// File: rtl/switch_allocator_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin picker: first eligible input at or after rr_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_INPORTS = 4,
  localparam int c_ptr_w = (NUM_INPORTS > 1) ? $clog2(NUM_INPORTS) : 1
) (
  input  logic [NUM_INPORTS-1:0] eligible,
  input  logic [c_ptr_w-1:0]     rr_ptr,
  output logic [NUM_INPORTS-1:0] winner,
  output logic                   valid
);

  logic [NUM_INPORTS-1:0] w_below;
  logic [NUM_INPORTS-1:0] w_masked;
  logic [NUM_INPORTS-1:0] w_pick_src;

  // Prefer candidates at or above the pointer; otherwise wrap to the lowest one.
  assign w_below    = (NUM_INPORTS'(1) << rr_ptr) - NUM_INPORTS'(1);
  assign w_masked   = eligible & ~w_below;
  assign w_pick_src = (|w_masked) ? w_masked : eligible;
  assign winner     = w_pick_src & (~w_pick_src + NUM_INPORTS'(1));
  assign valid      = |eligible;

endmodule
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator
// Description : Per-outport wormhole switch allocator with downstream credit
//               tracking. Define SWITCH_ALLOC_CREDIT_ERR_EN for credit_err.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator
  import chiplet_types_pkg::*;
#(
  parameter int NUM_INPORTS  = 4,
  parameter int NUM_OUTPORTS = 4,
  parameter int NUM_VCS      = 2,
  parameter int BUFFER_DEPTH = 8
) (
  input logic               CLK,
  input logic               nRST,
  switch_allocator_if.slave sw
);

  localparam int c_ptr_w = (NUM_INPORTS > 1) ? $clog2(NUM_INPORTS) : 1;
  localparam int c_vc_w  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int c_cnt_w = $clog2(BUFFER_DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(BUFFER_DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  for (genvar o = 0; o < NUM_OUTPORTS; o++) begin : g_port
    alloc_state_t           r_state;
    logic [c_ptr_w-1:0]     r_rr_ptr;
    logic [c_ptr_w-1:0]     r_winner;
    logic [c_vc_w-1:0]      r_vc;
    logic [NUM_INPORTS-1:0] r_grant;
    logic [c_cnt_w-1:0]     r_credit [NUM_VCS];

    logic [NUM_INPORTS-1:0] w_eligible;
    logic [NUM_INPORTS-1:0] w_win_oh;
    logic                   w_win_valid;
    logic [c_ptr_w-1:0]     w_win_idx;
    logic                   w_release;
    logic [NUM_VCS-1:0]     w_dec;

    always_comb begin
      w_eligible = '0;
      for (int i = 0; i < NUM_INPORTS; i++) begin
        if (sw.req[i][o] && (int'(sw.req_vc[i]) < NUM_VCS)) begin
          w_eligible[i] = (r_credit[sw.req_vc[i]] != '0);
        end
      end
    end

    rr_arbiter #(
      .NUM_INPORTS (NUM_INPORTS)
    ) u_rr_arbiter (
      .eligible (w_eligible),
      .rr_ptr   (r_rr_ptr),
      .winner   (w_win_oh),
      .valid    (w_win_valid)
    );

    always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < NUM_INPORTS; i++) begin
        if (w_win_oh[i]) begin
          w_win_idx = w_win_idx | c_ptr_w'(i);
        end
      end
    end

    assign w_release = (r_state == LOCKED) && sw.flit_sent[o] && sw.req_tail[r_winner];

    // Once locked, only the winner's tail flit frees the port; req is ignored.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        r_state  <= IDLE;
        r_rr_ptr <= '0;
        r_winner <= '0;
        r_vc     <= '0;
        r_grant  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_win_valid) begin
              r_state  <= LOCKED;
              r_winner <= w_win_idx;
              r_vc     <= sw.req_vc[w_win_idx];
              r_grant  <= w_win_oh;
            end
          end
          LOCKED: begin
            if (w_release) begin
              r_state  <= IDLE;
              r_grant  <= '0;
              r_rr_ptr <= c_ptr_w'(rr_next(int'(r_winner), NUM_INPORTS));
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end

    always_comb begin
      for (int v = 0; v < NUM_VCS; v++) begin
        w_dec[v] = (r_state == LOCKED) && sw.flit_sent[o] && (int'(r_vc) == v);
      end
    end

    // Counters saturate at both ends; a simultaneous send and return cancel.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        for (int v = 0; v < NUM_VCS; v++) begin
          r_credit[v] <= c_cnt_full;
        end
      end else begin
        for (int v = 0; v < NUM_VCS; v++) begin
          case ({w_dec[v], sw.credit_granted[o][v]})
            2'b10: begin
              if (r_credit[v] != '0) r_credit[v] <= r_credit[v] - c_cnt_one;
            end
            2'b01: begin
              if (r_credit[v] != c_cnt_full) r_credit[v] <= r_credit[v] + c_cnt_one;
            end
            default: begin
            end
          endcase
        end
      end
    end

    assign sw.grant[o]    = r_grant;
    assign sw.busy[o]     = (r_state == LOCKED);
    assign sw.vc_ready[o] = (r_state == LOCKED) && (r_credit[r_vc] != '0);

`ifdef SWITCH_ALLOC_CREDIT_ERR_EN
    logic               r_credit_err;
    logic [NUM_VCS-1:0] w_range_err;

    always_comb begin
      for (int v = 0; v < NUM_VCS; v++) begin
        w_range_err[v] = (w_dec[v] && !sw.credit_granted[o][v] && (r_credit[v] == '0)) ||
                         (!w_dec[v] && sw.credit_granted[o][v] && (r_credit[v] == c_cnt_full));
      end
    end

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        r_credit_err <= 1'b0;
      end else if (|w_range_err) begin
        r_credit_err <= 1'b1;
      end
    end

    assign sw.credit_err[o] = r_credit_err;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_allocator
// Description : Directed scoreboard bench for switch_allocator (depth 8 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;

`ifdef SWITCH_ALLOC_CREDIT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  switch_allocator_if #(.NUM_INPORTS(4), .NUM_OUTPORTS(4), .NUM_VCS(2)) a_if ();
  switch_allocator_if #(.NUM_INPORTS(4), .NUM_OUTPORTS(4), .NUM_VCS(2)) b_if ();

  switch_allocator #(
    .NUM_INPORTS(4), .NUM_OUTPORTS(4), .NUM_VCS(2), .BUFFER_DEPTH(8)
  ) u_dut_a (
    .CLK  (clk),
    .nRST (rst_n),
    .sw   (a_if.slave)
  );

  switch_allocator #(
    .NUM_INPORTS(4), .NUM_OUTPORTS(4), .NUM_VCS(2), .BUFFER_DEPTH(2)
  ) u_dut_b (
    .CLK  (clk),
    .nRST (rst_n),
    .sw   (b_if.slave)
  );

  typedef struct {
    bit          dut;
    logic [15:0] grant;
    logic [3:0]  busy;
    logic [3:0]  vr;
    logic [3:0]  err;
    string       name;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_err_a = 4'b0;
  logic [3:0] exp_err_b = 4'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end, required end");
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] act_err(input bit d);
`ifdef SWITCH_ALLOC_CREDIT_ERR_EN
    return d ? b_if.credit_err : a_if.credit_err;
`else
    return (d ? 4'b0 : 4'b0);
`endif
  endfunction

  // Monitor: one expectation per observed cycle, sampled after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        exp_t        e;
        logic [15:0] g;
        logic [3:0]  b;
        logic [3:0]  v;
        logic [3:0]  r;
        e = q.pop_front();
        g = e.dut ? b_if.grant    : a_if.grant;
        b = e.dut ? b_if.busy     : a_if.busy;
        v = e.dut ? b_if.vc_ready : a_if.vc_ready;
        r = act_err(e.dut);
        checks++;
        if (g !== e.grant || b !== e.busy || v !== e.vr || r !== e.err) begin
          errors++;
          $display("FAIL %s: got grant=%h busy=%b vc_ready=%b err=%b, required grant=%h busy=%b vc_ready=%b err=%b",
                   e.name, g, b, v, r, e.grant, e.busy, e.vr, e.err);
        end
      end
    end
  end

  task automatic cyc(input bit d, input logic [15:0] g, input logic [3:0] b,
                     input logic [3:0] vr, input string nm);
    exp_t e;
    e.dut   = d;
    e.grant = g;
    e.busy  = b;
    e.vr    = vr;
    e.err   = d ? exp_err_b : exp_err_a;
    e.name  = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic clr_a();
    a_if.req = '0; a_if.req_vc = '0; a_if.req_tail = '0;
    a_if.flit_sent = '0; a_if.credit_granted = '0;
  endtask

  task automatic clr_b();
    b_if.req = '0; b_if.req_vc = '0; b_if.req_tail = '0;
    b_if.flit_sent = '0; b_if.credit_granted = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_a();
    clr_b();
    @(negedge clk);
    cyc(1'b0, 16'h0000, 4'b0000, 4'b0000, "reset_a");
    cyc(1'b1, 16'h0000, 4'b0000, 4'b0000, "reset_b");
    rst_n = 1'b1;

    // Inputs 0 and 2 contend for outport 1; port 3 gets a credit while full.
    a_if.req[0][1] = 1'b1;
    a_if.req[2][1] = 1'b1;
    a_if.credit_granted[3][0] = 1'b1;
    exp_err_a = ERR_EN ? 4'b1000 : 4'b0000;
    cyc(1'b0, 16'h0010, 4'b0010, 4'b0010, "rr_first");
    a_if.credit_granted[3][0] = 1'b0;
    a_if.flit_sent[1] = 1'b1;
    cyc(1'b0, 16'h0010, 4'b0010, 4'b0010, "body_flit");
    a_if.req[0][1] = 1'b0;
    a_if.flit_sent[1] = 1'b0;
    repeat (3) cyc(1'b0, 16'h0010, 4'b0010, 4'b0010, "req_drop_hold");
    a_if.req[0][1] = 1'b1;
    a_if.req_tail[0] = 1'b1;
    a_if.flit_sent[1] = 1'b1;
    cyc(1'b0, 16'h0000, 4'b0000, 4'b0000, "tail_release");
    a_if.req[0][1] = 1'b0;
    a_if.req_tail[0] = 1'b0;
    a_if.flit_sent[1] = 1'b0;
    cyc(1'b0, 16'h0040, 4'b0010, 4'b0010, "rr_next");
    a_if.req_tail[2] = 1'b1;
    a_if.flit_sent[1] = 1'b1;
    cyc(1'b0, 16'h0000, 4'b0000, 4'b0000, "tail2");

    // Port 1 VC0 now holds 5 credits; send+return together must keep 5.
    a_if.req[2][1] = 1'b0;
    a_if.req_tail[2] = 1'b0;
    a_if.flit_sent[1] = 1'b0;
    a_if.req[1][1] = 1'b1;
    cyc(1'b0, 16'h0020, 4'b0010, 4'b0010, "grant_in1");
    a_if.flit_sent[1] = 1'b1;
    a_if.credit_granted[1][0] = 1'b1;
    cyc(1'b0, 16'h0020, 4'b0010, 4'b0010, "sent_and_credit");
    a_if.credit_granted[1][0] = 1'b0;
    repeat (4) cyc(1'b0, 16'h0020, 4'b0010, 4'b0010, "drain");
    cyc(1'b0, 16'h0020, 4'b0010, 4'b0000, "credit_empty");
    a_if.flit_sent[1] = 1'b0;
    a_if.credit_granted[1][0] = 1'b1;
    cyc(1'b0, 16'h0020, 4'b0010, 4'b0010, "credit_return");
    a_if.credit_granted[1][0] = 1'b0;
    a_if.req_tail[1] = 1'b1;
    a_if.flit_sent[1] = 1'b1;
    cyc(1'b0, 16'h0000, 4'b0000, 4'b0000, "tail3");

    // Drain port 2 VC1 to zero, leaving rr_ptr[2]=3.
    clr_a();
    a_if.req[2][2] = 1'b1;
    a_if.req_vc[2] = 1'b1;
    cyc(1'b0, 16'h0400, 4'b0100, 4'b0100, "lock_vc1");
    a_if.flit_sent[2] = 1'b1;
    repeat (7) cyc(1'b0, 16'h0400, 4'b0100, 4'b0100, "vc1_drain");
    a_if.req_tail[2] = 1'b1;
    cyc(1'b0, 16'h0000, 4'b0000, 4'b0000, "vc1_tail");
    clr_a();
    a_if.req[3][2] = 1'b1;
    a_if.req_vc[3] = 1'b1;
    a_if.req[1][2] = 1'b1;
    a_if.req_vc[1] = 1'b0;
    cyc(1'b0, 16'h0200, 4'b0100, 4'b0100, "credit_gate");
    cyc(1'b0, 16'h0200, 4'b0100, 4'b0100, "gate_hold");

    // Asynchronous reset in the middle of the packet.
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_if.grant !== '0 || a_if.busy !== 4'b0 || a_if.vc_ready !== 4'b0 || act_err(1'b0) !== 4'b0) begin
      errors++;
      $display("FAIL async_reset: got grant=%h busy=%b vc_ready=%b err=%b, required all zero",
               a_if.grant, a_if.busy, a_if.vc_ready, act_err(1'b0));
    end
    exp_err_a = 4'b0000;
    @(negedge clk);
    cyc(1'b0, 16'h0000, 4'b0000, 4'b0000, "reset_hold");
    rst_n = 1'b1;
    clr_a();
    a_if.req[0][1] = 1'b1;
    cyc(1'b0, 16'h0010, 4'b0010, 4'b0010, "post_reset_credit");
    clr_a();

    // Depth-2 instance: three flits with no return, then one credit back.
    b_if.req[0][0] = 1'b1;
    cyc(1'b1, 16'h0001, 4'b0001, 4'b0001, "b_lock");
    b_if.flit_sent[0] = 1'b1;
    cyc(1'b1, 16'h0001, 4'b0001, 4'b0001, "b_flit1");
    cyc(1'b1, 16'h0001, 4'b0001, 4'b0000, "b_flit2");
    exp_err_b = ERR_EN ? 4'b0001 : 4'b0000;
    cyc(1'b1, 16'h0001, 4'b0001, 4'b0000, "b_underflow");
    b_if.flit_sent[0] = 1'b0;
    b_if.credit_granted[0][0] = 1'b1;
    cyc(1'b1, 16'h0001, 4'b0001, 4'b0001, "b_credit");
    b_if.credit_granted[0][0] = 1'b0;
    cyc(1'b1, 16'h0001, 4'b0001, 4'b0001, "b_hold");
    clr_b();

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
